mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-CPU memory arbiter: data requests beat instruction requests, round-robin within a class,
// one RAM transaction per GRANT with a bounded wait for ramstate ACCESS.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [4:0] CNT_LAST   = 5'(TIMEOUT - 1);

    state_e     state_q;
    logic       gcpu_q;
    logic       gdata_q;
    logic       rrptr_q;
    logic [4:0] cnt_q;

    logic [1:0] dreq;
    logic [1:0] cand;
    logic       any_d;
    logic       win_cpu;
    logic       access;
    logic       g_req;
    logic       grant_done;

    assign dreq    = dREN | dWEN;
    assign any_d   = |dreq;
    assign cand    = any_d ? dreq : iREN;
    assign win_cpu = cand[rrptr_q] ? rrptr_q : ~rrptr_q;
    assign access  = (ramstate == RAM_ACCESS);

    // The granted request is re-sampled every GRANT cycle; if it drops, the grant ends quietly.
    assign g_req      = gdata_q ? dreq[gcpu_q] : iREN[gcpu_q];
    assign grant_done = (state_q == GRANT) && g_req && access;
    assign timeout    = (state_q == GRANT) && g_req && !access && (cnt_q == CNT_LAST);

    assign iload = {2{ramload}};
    assign dload = {2{ramload}};

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gcpu_q  <= 1'b0;
            gdata_q <= 1'b0;
            rrptr_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q <= GRANT;
                        gcpu_q  <= win_cpu;
                        gdata_q <= any_d;
                        rrptr_q <= ~win_cpu;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (!g_req || access || cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        if (state_q == GRANT) begin
            if (gdata_q) begin
                ramaddr  = daddr[gcpu_q];
                ramWEN   = dWEN[gcpu_q];
                ramREN   = dREN[gcpu_q] & ~dWEN[gcpu_q];
                ramstore = dstore[gcpu_q];
            end else begin
                ramaddr = iaddr[gcpu_q];
                ramREN  = iREN[gcpu_q];
            end
        end
        if (grant_done) begin
            if (gdata_q) dwait[gcpu_q] = 1'b0;
            else         iwait[gcpu_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, data priority, round-robin,
// timeout abort and reset during a write grant.
module tb_mem_arbiter;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;
    logic             timeout;

    int tests  = 0;
    int failed = 0;

    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'h0; ramstate = S_FREE;
        iREN[0] = 1'b1; dWEN[1] = 1'b1;
        tick();
        tests++;
        if ({ramREN, ramWEN, iwait, dwait, timeout} !== 7'b0011110) begin
            failed++;
            $display("FAIL reset_ctrl: got %b want %b", {ramREN, ramWEN, iwait, dwait, timeout}, 7'b0011110);
        end
        tests++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            failed++;
            $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore});
        end
        iREN = '0; dWEN = '0;
        RST = 1'b0;
    endtask

    task automatic test_single_fetch();
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = S_ACCESS; ramload = 32'h1234_5678;
        #1;
        tests++;
        if ({ramREN, iwait} !== 3'b011) begin
            failed++;
            $display("FAIL fetch_idle: got %b want %b", {ramREN, iwait}, 3'b011);
        end
        tick();
        tests++;
        if ({ramREN, ramWEN, iwait, dwait} !== 6'b101011 || ramaddr !== 32'h40) begin
            failed++;
            $display("FAIL fetch_grant: got %b addr %h want %b addr 40", {ramREN, ramWEN, iwait, dwait}, ramaddr, 6'b101011);
        end
        tests++;
        if (iload[0] !== 32'h1234_5678 || dload[1] !== 32'h1234_5678) begin
            failed++;
            $display("FAIL load_fanout: got %h %h want 12345678", iload[0], dload[1]);
        end
        tick();
        tests++;
        if ({ramREN, iwait} !== 3'b011 || ramaddr !== 32'h0) begin
            failed++;
            $display("FAIL fetch_done: got %b addr %h want 011 addr 0", {ramREN, iwait}, ramaddr);
        end
        iREN[0] = 1'b0;
    endtask

    // rrptr is 1 here; dREN and dWEN both high must still be a write.
    task automatic test_data_priority();
        iREN[0] = 1'b1; iaddr[0] = 32'h44;
        dWEN[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h80; dstore[1] = 32'hDEAD_BEEF;
        tick();
        tests++;
        if ({ramREN, ramWEN, iwait, dwait} !== 6'b011101) begin
            failed++;
            $display("FAIL prio_ctrl: got %b want %b", {ramREN, ramWEN, iwait, dwait}, 6'b011101);
        end
        tests++;
        if (ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF) begin
            failed++;
            $display("FAIL prio_bus: got %h/%h want 00000080/deadbeef", ramaddr, ramstore);
        end
        dWEN[1] = 1'b0; dREN[1] = 1'b0;
        tick();
        tests++;
        if ({ramWEN, iwait} !== 3'b011) begin
            failed++;
            $display("FAIL prio_gap: got %b want 011", {ramWEN, iwait});
        end
        tick();
        tests++;
        if ({ramREN, iwait} !== 3'b110 || ramaddr !== 32'h44) begin
            failed++;
            $display("FAIL prio_ifetch: got %b addr %h want 110 addr 44", {ramREN, iwait}, ramaddr);
        end
        iREN[0] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_dwait [6] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        logic [31:0] exp_addr  [6] = '{32'h100, 32'h0, 32'h200, 32'h0, 32'h100, 32'h0};
        RST = 1'b1; #1; RST = 1'b0;
        dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200; ramstate = S_ACCESS;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (dwait !== exp_dwait[i] || ramaddr !== exp_addr[i] || ramREN !== (i % 2 == 0)) begin
                failed++;
                $display("FAIL rr_step%0d: got dwait %b addr %h ren %b want %b %h", i, dwait, ramaddr, ramREN, exp_dwait[i], exp_addr[i]);
            end
        end
        dREN = 2'b00;
        tick();
    endtask

    // rrptr is 1 here; BUSY and ERROR both keep the grant waiting.
    task automatic test_timeout();
        int pulses = 0;
        iREN[1] = 1'b1; iaddr[1] = 32'h300; ramstate = S_BUSY;
        tick();
        for (int i = 0; i < 16; i++) begin
            ramstate = (i >= 5 && i <= 7) ? S_ERROR : S_BUSY;
            #1;
            if (timeout) pulses++;
            tests++;
            if ({ramREN, iwait, timeout} !== {1'b1, 2'b11, (i == 15)} || ramaddr !== 32'h300) begin
                failed++;
                $display("FAIL to_cycle%0d: got %b addr %h want %b", i, {ramREN, iwait, timeout}, ramaddr, {1'b1, 2'b11, (i == 15)});
            end
            tick();
        end
        tests++;
        if (pulses != 1 || {ramREN, iwait, timeout} !== 4'b0110) begin
            failed++;
            $display("FAIL to_abort: got pulses %0d ctrl %b want 1 0110", pulses, {ramREN, iwait, timeout});
        end
        tick();
        tests++;
        if ({ramREN, iwait, timeout} !== 4'b1110) begin
            failed++;
            $display("FAIL to_rearb: got %b want 1110", {ramREN, iwait, timeout});
        end
        // Request withdrawn while ACCESS shows: grant ends with no wait released.
        iREN[1] = 1'b0; ramstate = S_ACCESS;
        #1;
        tests++;
        if (iwait !== 2'b11 || timeout !== 1'b0) begin
            failed++;
            $display("FAIL withdraw: got %b/%b want 11/0", iwait, timeout);
        end
        tick();
        tests++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
            failed++;
            $display("FAIL withdraw_idle: got %b %h want 0 0", ramREN, ramaddr);
        end
    endtask

    task automatic test_reset_mid_grant();
        dWEN[0] = 1'b1; daddr[0] = 32'h500; dstore[0] = 32'hCAFE_F00D; ramstate = S_BUSY;
        tick();
        tests++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h500) begin
            failed++;
            $display("FAIL rst_pre: got %b %h want 1 500", ramWEN, ramaddr);
        end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if ({ramWEN, ramREN, iwait, dwait, timeout} !== 7'b0011110 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            failed++;
            $display("FAIL rst_abort: got %b %h %h want 0011110 0 0", {ramWEN, ramREN, iwait, dwait, timeout}, ramaddr, ramstore);
        end
        dWEN[0] = 1'b0;
        dREN = 2'b11; ramstate = S_ACCESS;
        tick();
        RST = 1'b0;
        tick();
        tests++;
        if (dwait !== 2'b10 || ramaddr !== 32'h500) begin
            failed++;
            $display("FAIL rst_rrptr: got %b %h want 10 500", dwait, ramaddr);
        end
        dREN = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_priority();
        test_round_robin();
        test_timeout();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
